mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - RV32 load/store access unit between the EX/MEM stage and a busywait data memory.
// Validates, latches and issues one memory transfer per request, then formats load data for MEM/WB.
module mem_access_unit (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        IN_MEM_READ,
  input  logic        IN_MEM_WRITE,
  input  logic [2:0]  IN_FUNC3,
  input  logic [31:0] IN_ADDRESS,
  input  logic [31:0] IN_WRITE_DATA,
  output logic [31:0] OUT_DMEM_OUT,
  output logic        BUSYWAIT,
  output logic        OUT_ACCESS_FAULT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [29:0] MEM_ADDRESS,
  output logic [3:0]  MEM_BYTE_EN,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic        r_is_load;
  logic [2:0]  r_func3;
  logic [1:0]  r_addr_lo;
  logic        r_mem_read;
  logic        r_mem_write;
  logic [29:0] r_mem_address;
  logic [3:0]  r_byte_en;
  logic [31:0] r_writedata;
  logic [31:0] r_dmem_out;
  logic        r_fault;

  logic        w_req_any;
  logic        w_func3_legal;
  logic        w_misaligned;
  logic        w_valid;
  logic        w_illegal;
  logic        w_accept;
  logic        w_complete;
  logic [3:0]  w_byte_en;
  logic [31:0] w_writedata;
  logic [7:0]  w_lane_byte;
  logic [15:0] w_lane_half;
  logic [31:0] w_load_fmt;

  // Request qualification: one direction only, legal funct3, natural alignment.
  assign w_req_any = IN_MEM_READ | IN_MEM_WRITE;

  always_comb begin
    w_func3_legal = 1'b0;
    if (IN_MEM_READ) begin
      case (IN_FUNC3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_func3_legal = 1'b1;
        default:                                 w_func3_legal = 1'b0;
      endcase
    end else begin
      case (IN_FUNC3)
        3'b000, 3'b001, 3'b010: w_func3_legal = 1'b1;
        default:                w_func3_legal = 1'b0;
      endcase
    end
  end

  assign w_misaligned = ((IN_FUNC3[1:0] == 2'b01) && IN_ADDRESS[0]) ||
                        ((IN_FUNC3[1:0] == 2'b10) && (IN_ADDRESS[1:0] != 2'b00));
  assign w_valid      = (IN_MEM_READ ^ IN_MEM_WRITE) && w_func3_legal && !w_misaligned;
  assign w_illegal    = w_req_any && !w_valid;
  assign w_accept     = (r_state == S_IDLE) && w_valid;
  assign w_complete   = (r_state == S_ACCESS) && !MEM_BUSYWAIT;

  always_comb begin
    w_byte_en   = 4'b1111;
    w_writedata = IN_WRITE_DATA;
    if (IN_MEM_WRITE) begin
      case (IN_FUNC3[1:0])
        2'b00: begin
          w_byte_en   = 4'b0001 << IN_ADDRESS[1:0];
          w_writedata = {4{IN_WRITE_DATA[7:0]}};
        end
        2'b01: begin
          w_byte_en   = 4'b0011 << IN_ADDRESS[1:0];
          w_writedata = {2{IN_WRITE_DATA[15:0]}};
        end
        default: begin
          w_byte_en   = 4'b1111;
          w_writedata = IN_WRITE_DATA;
        end
      endcase
    end
  end

  // Load formatting uses the latched offset, never the live pipeline address.
  always_comb begin
    case (r_addr_lo)
      2'b00:   w_lane_byte = MEM_READDATA[7:0];
      2'b01:   w_lane_byte = MEM_READDATA[15:8];
      2'b10:   w_lane_byte = MEM_READDATA[23:16];
      default: w_lane_byte = MEM_READDATA[31:24];
    endcase
    w_lane_half = r_addr_lo[1] ? MEM_READDATA[31:16] : MEM_READDATA[15:0];
    case (r_func3)
      3'b000:  w_load_fmt = {{24{w_lane_byte[7]}}, w_lane_byte};
      3'b001:  w_load_fmt = {{16{w_lane_half[15]}}, w_lane_half};
      3'b100:  w_load_fmt = {24'd0, w_lane_byte};
      3'b101:  w_load_fmt = {16'd0, w_lane_half};
      default: w_load_fmt = MEM_READDATA;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_valid) w_next_state = S_ACCESS;
      S_ACCESS: if (!MEM_BUSYWAIT) w_next_state = S_DONE;
      S_DONE:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // The stall is raised in the accepting IDLE cycle so the pipeline freezes immediately.
  always_comb begin
    BUSYWAIT = 1'b0;
    if (!RESET) begin
      case (r_state)
        S_IDLE:   BUSYWAIT = w_valid;
        S_ACCESS: BUSYWAIT = 1'b1;
        default:  BUSYWAIT = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_is_load     <= 1'b0;
      r_func3       <= 3'b000;
      r_addr_lo     <= 2'b00;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_address <= 30'd0;
      r_byte_en     <= 4'b0000;
      r_writedata   <= 32'd0;
      r_dmem_out    <= 32'd0;
      r_fault       <= 1'b0;
    end else begin
      r_fault <= (r_state == S_IDLE) && w_illegal;
      if (w_accept) begin
        r_is_load     <= IN_MEM_READ;
        r_func3       <= IN_FUNC3;
        r_addr_lo     <= IN_ADDRESS[1:0];
        r_mem_read    <= IN_MEM_READ;
        r_mem_write   <= IN_MEM_WRITE;
        r_mem_address <= IN_ADDRESS[31:2];
        r_byte_en     <= w_byte_en;
        r_writedata   <= w_writedata;
      end else if (w_complete) begin
        r_mem_read  <= 1'b0;
        r_mem_write <= 1'b0;
        if (r_is_load) begin
          r_dmem_out <= w_load_fmt;
        end
      end
    end
  end

  assign OUT_DMEM_OUT     = r_dmem_out;
  assign OUT_ACCESS_FAULT = r_fault;
  assign MEM_READ         = r_mem_read;
  assign MEM_WRITE        = r_mem_write;
  assign MEM_ADDRESS      = r_mem_address;
  assign MEM_BYTE_EN      = r_byte_en;
  assign MEM_WRITEDATA    = r_writedata;

endmodule
